// File: rtl/lab_a1_pkg.sv
// Shared types and defaults for the lab A1 response checker.
package lab_a1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_W_DEF   = 4;
  localparam int NUM_VEC_DEF = 16;

endpackage

// File: rtl/lab_a1_fail_log.sv
// Mismatch bookkeeping: running mismatch count and the first failing vector of a sweep.
module lab_a1_fail_log
  import lab_a1_pkg::*;
#(
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             log_en,
  input  logic             mismatch,
  input  logic [VEC_W-1:0] vec,
  output logic [VEC_W:0]   mismatch_cnt,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [VEC_W:0] CNT_ONE = {{VEC_W{1'b0}}, 1'b1};

  logic [VEC_W:0]   r_cnt;
  logic             r_ff_valid;
  logic [VEC_W-1:0] r_ff_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (clear) begin
      r_cnt      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (log_en && mismatch) begin
      r_cnt <= r_cnt + CNT_ONE;
      // Only the earliest failure of the sweep is kept.
      if (!r_ff_valid) begin
        r_ff_valid <= 1'b1;
        r_ff_vec   <= vec;
      end
    end
  end

  assign mismatch_cnt     = r_cnt;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule

// File: rtl/lab_a1_resp_checker.sv
// Response checker for the A1 exhaustive sweep: ordering check, sample compare,
// and pass/fail once every vector has been accepted.
module lab_a1_resp_checker
  import lab_a1_pkg::*;
#(
  parameter int VEC_W   = VEC_W_DEF,
  parameter int NUM_VEC = 2 ** VEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             in_x1,
  input  logic             in_y1,
  input  logic             in_x2,
  input  logic             in_y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VEC_W:0]   mismatch_cnt,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             seq_err
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [VEC_W-1:0] VEC_ONE  = {{(VEC_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_exp_vec;
  logic             r_seq_err;
  logic             r_pass;

  logic w_xfer;
  logic w_clear;
  logic w_mis;
  logic w_last;
  logic w_seq_bad;
  logic w_pass_nxt;

  assign w_xfer    = in_valid && (r_state == ST_RUN);
  assign w_clear   = start && (r_state != ST_RUN);
  assign w_mis     = ({in_x1, in_y1} != {in_x2, in_y2});
  assign w_last    = (r_exp_vec == LAST_VEC);
  assign w_seq_bad = (in_vec != r_exp_vec);

  // Verdict folds in the final sample itself, since its count update lands on the same edge.
  assign w_pass_nxt = (mismatch_cnt == '0) && !w_mis && !r_seq_err && !w_seq_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)            w_state_nxt = ST_RUN;
      ST_RUN:  if (w_xfer && w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (start)            w_state_nxt = ST_RUN;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_vec <= '0;
      r_seq_err <= 1'b0;
      r_pass    <= 1'b0;
    end else if (w_clear) begin
      r_exp_vec <= '0;
      r_seq_err <= 1'b0;
      r_pass    <= 1'b0;
    end else if (w_xfer) begin
      r_exp_vec <= r_exp_vec + VEC_ONE;
      if (w_seq_bad) r_seq_err <= 1'b1;
      if (w_last)    r_pass    <= w_pass_nxt;
    end
  end

  lab_a1_fail_log #(
    .VEC_W (VEC_W)
  ) u_fail_log (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (w_clear),
    .log_en           (w_xfer),
    .mismatch         (w_mis),
    .vec              (in_vec),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  assign in_ready = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign pass     = r_pass;
  assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_lab_a1_resp_checker.sv
// Self-checking bench for lab_a1_resp_checker: sweep-level model plus directed scenarios.
module tb_lab_a1_resp_checker;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [VEC_W-1:0] in_vec = '0;
  logic             in_x1 = 1'b0, in_y1 = 1'b0, in_x2 = 1'b0, in_y2 = 1'b0;
  logic             in_ready, busy, done, pass, first_fail_valid, seq_err;
  logic [VEC_W:0]   mismatch_cnt;
  logic [VEC_W-1:0] first_fail_vec;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  lab_a1_resp_checker #(.VEC_W(VEC_W), .NUM_VEC(NUM_VEC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_vec           (in_vec),
    .in_x1            (in_x1),
    .in_y1            (in_y1),
    .in_x2            (in_x2),
    .in_y2            (in_y2),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .seq_err          (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep-level model: phase 0=idle 1=run 2=done, m_n counts accepted samples.
  int m_phase, m_n, m_cnt, m_ffvec;
  bit m_ffv, m_seq, m_pass;
  wire m_mis = ({in_x1, in_y1} != {in_x2, in_y2});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_n <= 0; m_cnt <= 0; m_ffvec <= 0;
      m_ffv <= 1'b0; m_seq <= 1'b0; m_pass <= 1'b0;
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_n <= m_n + 1;
        if (m_mis) m_cnt <= m_cnt + 1;
        if (m_mis && !m_ffv) begin
          m_ffv   <= 1'b1;
          m_ffvec <= int'(in_vec);
        end
        if (int'(in_vec) != m_n) m_seq <= 1'b1;
        if (m_n == NUM_VEC - 1) begin
          m_phase <= 2;
          m_pass  <= (m_cnt == 0) && !m_mis && !m_seq && (int'(in_vec) == m_n);
        end
      end
    end else if (start) begin
      m_phase <= 1; m_n <= 0; m_cnt <= 0; m_ffvec <= 0;
      m_ffv <= 1'b0; m_seq <= 1'b0; m_pass <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", int'(in_ready), int'(m_phase == 1));
      chk("busy", int'(busy), int'(m_phase == 1));
      chk("done", int'(done), int'(m_phase == 2));
      chk("pass", int'(pass), int'(m_pass));
      chk("mismatch_cnt", int'(mismatch_cnt), m_cnt);
      chk("first_fail_valid", int'(first_fail_valid), int'(m_ffv));
      chk("first_fail_vec", int'(first_fail_vec), m_ffvec);
      chk("seq_err", int'(seq_err), int'(m_seq));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [VEC_W-1:0] v, input logic x1, input logic y1,
                      input logic x2, input logic y2, input int gap);
    in_vec = v; in_x1 = x1; in_y1 = y1; in_x2 = x2; in_y2 = y2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  // bad_a/bad_b: sample indices whose y2 is inverted; seq_idx is sent as seq_val.
  task automatic sweep(input int bad_a, input int bad_b, input int seq_idx,
                       input int seq_val, input bit gaps, input int count);
    logic [VEC_W-1:0] v;
    logic x, y;
    for (int i = 0; i < count; i++) begin
      v = (i == seq_idx) ? VEC_W'(seq_val) : VEC_W'(i);
      x = v[0] ^ v[3];
      y = v[1] | v[2];
      send(v, x, y, x, ((i == bad_a) || (i == bad_b)) ? ~y : y,
           gaps ? int'($urandom_range(0, 5)) : 0);
    end
  endtask

  function automatic int all_outs();
    return int'({in_ready, busy, done, pass, mismatch_cnt, first_fail_valid,
                 first_fail_vec, seq_err});
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // in_valid while idle must be ignored
    send(4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("idle_valid_cnt", int'(mismatch_cnt), 0);

    // clean sweep
    pulse_start();
    chk("run_busy", int'(busy), 1);
    sweep(-1, -1, -1, 0, 1'b0, 15);
    chk("done_before_last", int'(done), 0);
    sweep(-1, -1, -1, 0, 1'b0, 0);
    send(4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    chk("s1_done", int'(done), 1);
    chk("s1_pass", int'(pass), 1);
    chk("s1_cnt", int'(mismatch_cnt), 0);
    chk("s1_seq", int'(seq_err), 0);
    chk("s1_ffv", int'(first_fail_valid), 0);

    // two mismatches at 5 and 11
    pulse_start();
    chk("s2_done_drop", int'(done), 0);
    sweep(5, 11, -1, 0, 1'b0, 16);
    chk("s2_done", int'(done), 1);
    chk("s2_cnt", int'(mismatch_cnt), 2);
    chk("s2_ffvec", int'(first_fail_vec), 5);
    chk("s2_ffv", int'(first_fail_valid), 1);
    chk("s2_pass", int'(pass), 0);

    // restart from DONE after a failure
    pulse_start();
    chk("s6_cleared_cnt", int'(mismatch_cnt), 0);
    chk("s6_cleared_ffv", int'(first_fail_valid), 0);
    sweep(-1, -1, -1, 0, 1'b0, 16);
    chk("s6_pass", int'(pass), 1);
    chk("s6_ffv", int'(first_fail_valid), 0);

    // sequence error: index 7 sent as 9
    pulse_start();
    sweep(-1, -1, 7, 9, 1'b0, 16);
    chk("s3_done", int'(done), 1);
    chk("s3_seq", int'(seq_err), 1);
    chk("s3_cnt", int'(mismatch_cnt), 0);
    chk("s3_pass", int'(pass), 0);

    // gapped valid, then a 17th mismatching pulse
    pulse_start();
    sweep(-1, -1, -1, 0, 1'b1, 16);
    chk("s4_pass", int'(pass), 1);
    chk("s4_cnt", int'(mismatch_cnt), 0);
    chk("s4_ready", int'(in_ready), 0);
    send(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    chk("s4_extra_cnt", int'(mismatch_cnt), 0);
    chk("s4_extra_done", int'(done), 1);

    // reset mid-sweep, with a mismatch already logged
    pulse_start();
    sweep(2, -1, -1, 0, 1'b0, 8);
    chk("s5_pre_cnt", int'(mismatch_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_reset", all_outs(), 0);
    #2;
    rst_n = 1'b1;
    step();
    pulse_start();
    sweep(-1, -1, -1, 0, 1'b0, 16);
    chk("s5_pass", int'(pass), 1);
    chk("s5_done", int'(done), 1);

    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
